rf_writeback: RTL and testbench

- Write-side master for the 16-bit, 32-entry register file.
- Accepts retiring results from the ALU and memory stages over valid/ready handshakes and buffers them in a small FIFO.
- Drives the register file's two-phase write protocol: destination latched on a non-write cycle, data written on the following `reg_wrt` cycle.
- Provides a forwarding lookup so decode can read values that are still pending in the buffer.

---
 rtl/rf_wb_pkg.sv | 23 ++
 rtl/wb_fifo.sv | 62 ++++++
 rtl/rf_writeback.sv | 140 ++++++++++++++
 tb/tb_rf_writeback.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg
// Shared types and constants for the register-file write-back block.
//   DATA_W     : register data width
//   ADDR_W     : register index width
//   wb_entry_t : one pending register write {dest, data}
//   wb_state_t : write-protocol FSM states
package rf_wb_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WRITE = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo
// Circular buffer of pending register writes with two push ports and one pop.
// When both pushes fire in the same cycle, push0 lands ahead of push1.
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   push0, push0_entry      : first (older) enqueue port
//   push1, push1_entry      : second (younger) enqueue port
//   pop                     : drop the head entry
//   count                   : number of valid entries
//   entries                 : buffer contents, oldest first (entries[0] = head)
module wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push0,
  input  wb_entry_t             push0_entry,
  input  logic                  push1,
  input  wb_entry_t             push1_entry,
  input  logic                  pop,
  output logic [CW-1:0]         count,
  output wb_entry_t [DEPTH-1:0] entries
);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_ptr1;

  // push1 goes into the slot after push0 only when push0 also fires
  assign wr_ptr1 = wr_ptr + PW'(push0);

  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr] <= push0_entry;
    if (push1) mem[wr_ptr1] <= push1_entry;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push0) + PW'(push1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  // Age-ordered view so consumers never deal with pointer arithmetic
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i] = mem[rd_ptr + PW'(i)];
    end
  end

endmodule

// File: rtl/rf_writeback.sv
// rf_writeback
// Write-side master for the 16-bit, 32-entry register file. Retiring results
// from the memory and ALU stages are buffered and written out with the
// register file's two-phase protocol (destination cycle, then write cycle).
// Ports:
//   clk, rst                              : clock, asynchronous active-high reset
//   mem_valid/mem_ready/mem_dest/mem_data : memory-stage result handshake
//   alu_valid/alu_ready/alu_dest/alu_data : ALU result handshake
//   reg_wrt, dest, data                   : registered register-file write port
//   fwd_readA/B -> fwd_hit_a/b, fwd_data_a/b : lookup of still-pending writes
//   busy                                  : pending writes or a write in progress
module rf_writeback
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  output logic              reg_wrt,
  output logic [ADDR_W-1:0] dest,
  output logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] fwd_readA,
  input  logic [ADDR_W-1:0] fwd_readB,
  output logic              fwd_hit_a,
  output logic              fwd_hit_b,
  output logic [DATA_W-1:0] fwd_data_a,
  output logic [DATA_W-1:0] fwd_data_b,
  output logic              busy
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int CW1 = CW + 1;
  localparam logic [CW:0] FULL = CW1'(DEPTH);

  logic [CW-1:0]         count;
  wb_entry_t [DEPTH-1:0] entries;
  wb_entry_t             head;
  wb_state_t             state;
  logic                  mem_fire;
  logic                  alu_fire;
  logic                  push0;
  logic                  push1;
  logic                  pop;
  logic [CW:0]           alu_level;

  // Credit comes only from the registered count; a same-cycle pop frees nothing
  assign mem_ready = {1'b0, count} < FULL;
  assign mem_fire  = mem_valid & mem_ready;
  assign alu_level = {1'b0, count} + CW1'(mem_fire);
  assign alu_ready = alu_level < FULL;
  assign alu_fire  = alu_valid & alu_ready;

  // Writes to r0 complete the handshake but are dropped here
  assign push0 = mem_fire & (mem_dest != '0);
  assign push1 = alu_fire & (alu_dest != '0);
  assign pop   = (state == WRITE);
  assign head  = entries[0];

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push0       (push0),
    .push0_entry ('{dest: mem_dest, data: mem_data}),
    .push1       (push1),
    .push1_entry ('{dest: alu_dest, data: alu_data}),
    .pop         (pop),
    .count       (count),
    .entries     (entries)
  );

  // Leaving WRITE pops the head, so the next ADDR cycle presents entries[1]
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      reg_wrt <= 1'b0;
      dest    <= '0;
      data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          reg_wrt <= 1'b0;
          if (count != '0) begin
            state <= ADDR;
            dest  <= head.dest;
          end
        end
        ADDR: begin
          state   <= WRITE;
          reg_wrt <= 1'b1;
          dest    <= head.dest;
          data    <= head.data;
        end
        WRITE: begin
          reg_wrt <= 1'b0;
          if (count > CW'(1)) begin
            state <= ADDR;
            dest  <= entries[1].dest;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          reg_wrt <= 1'b0;
        end
      endcase
    end
  end

  // Scan oldest to youngest so the youngest match overwrites older ones
  always_comb begin
    fwd_hit_a  = 1'b0;
    fwd_hit_b  = 1'b0;
    fwd_data_a = '0;
    fwd_data_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) begin
        if ((fwd_readA != '0) && (entries[i].dest == fwd_readA)) begin
          fwd_hit_a  = 1'b1;
          fwd_data_a = entries[i].data;
        end
        if ((fwd_readB != '0) && (entries[i].dest == fwd_readB)) begin
          fwd_hit_b  = 1'b1;
          fwd_data_b = entries[i].data;
        end
      end
    end
  end

  assign busy = (count != '0) || (state != IDLE);

endmodule

// File: tb/tb_rf_writeback.sv
// tb_rf_writeback
// Self-checking bench for rf_writeback: table of single writes, directed
// multi-cycle sequences, and a randomized run against a behavioural model.
// The model keeps accepted writes in an ordered list; each write happens two
// edges after it is accepted, and never sooner than two edges after the
// previous write; an entry leaves the buffer on the edge after its write.
module tb_rf_writeback;
  import rf_wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXE  = 4096;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_valid, mem_ready;
  logic [ADDR_W-1:0] mem_dest;
  logic [DATA_W-1:0] mem_data;
  logic              alu_valid, alu_ready;
  logic [ADDR_W-1:0] alu_dest;
  logic [DATA_W-1:0] alu_data;
  logic              reg_wrt;
  logic [ADDR_W-1:0] dest;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] fwd_readA, fwd_readB;
  logic              fwd_hit_a, fwd_hit_b;
  logic [DATA_W-1:0] fwd_data_a, fwd_data_b;
  logic              busy;

  rf_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .reg_wrt(reg_wrt), .dest(dest), .data(data),
    .fwd_readA(fwd_readA), .fwd_readB(fwd_readB),
    .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
    .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state
  int m_dest [MAXE];
  int m_data [MAXE];
  int m_wr   [MAXE];
  int n_ent, pop_idx, last_wr;
  int exp_count;
  bit e_mr, e_ar, e_wrt, e_hit_a, e_hit_b;
  int e_dest, e_data, e_fa, e_fb;

  bit fire_m, fire_a;
  int pm_dest, pm_data, pa_dest, pa_data;

  typedef struct {
    bit                use_mem;
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] dat;
    bit                exp_pulse;
    logic [ADDR_W-1:0] exp_dest;
    logic [DATA_W-1:0] exp_data;
  } vec_t;

  vec_t vecs [6];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic modelReset();
    n_ent   = 0;
    pop_idx = 0;
    last_wr = -100;
    fire_m  = 1'b0;
    fire_a  = 1'b0;
  endtask

  task automatic modelEval();
    while (pop_idx < n_ent && m_wr[pop_idx] + 1 <= cyc) pop_idx++;
    exp_count = n_ent - pop_idx;
    e_mr = exp_count < DEPTH;
    e_ar = (exp_count + ((mem_valid && e_mr) ? 1 : 0)) < DEPTH;
    e_wrt = 0; e_dest = 0; e_data = 0;
    e_hit_a = 0; e_hit_b = 0; e_fa = 0; e_fb = 0;
    for (int k = pop_idx; k < n_ent; k++) begin
      if (m_wr[k] == cyc) begin
        e_wrt = 1; e_dest = m_dest[k]; e_data = m_data[k];
      end
      if (fwd_readA != 0 && m_dest[k] == int'(fwd_readA)) begin
        e_hit_a = 1; e_fa = m_data[k];
      end
      if (fwd_readB != 0 && m_dest[k] == int'(fwd_readB)) begin
        e_hit_b = 1; e_fb = m_data[k];
      end
    end
  endtask

  task automatic enqueue(input int d, input int v);
    int w;
    if (d == 0) return;
    w = cyc + 2;
    if (last_wr + 2 > w) w = last_wr + 2;
    m_dest[n_ent] = d;
    m_data[n_ent] = v;
    m_wr[n_ent]   = w;
    last_wr = w;
    n_ent++;
  endtask

  // Drive one cycle's inputs, then compare every output against the model
  task automatic applyStimulus(input logic mv, input logic [ADDR_W-1:0] md, input logic [DATA_W-1:0] mdat,
                               input logic av, input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] adat,
                               input logic [ADDR_W-1:0] qa, input logic [ADDR_W-1:0] qb);
    mem_valid = mv; mem_dest = md; mem_data = mdat;
    alu_valid = av; alu_dest = ad; alu_data = adat;
    fwd_readA = qa; fwd_readB = qb;
    #1;
    modelEval();
    checkOutput("mem_ready", mem_ready, e_mr);
    checkOutput("alu_ready", alu_ready, e_ar);
    checkOutput("reg_wrt", reg_wrt, e_wrt);
    checkOutput("busy", busy, exp_count != 0);
    checkOutput("fwd_hit_a", fwd_hit_a, e_hit_a);
    checkOutput("fwd_hit_b", fwd_hit_b, e_hit_b);
    checkOutput("fwd_data_a", fwd_data_a, e_fa);
    checkOutput("fwd_data_b", fwd_data_b, e_fb);
    if (e_wrt) begin
      checkOutput("dest", dest, e_dest);
      checkOutput("data", data, e_data);
    end
    fire_m = mv && e_mr;
    fire_a = av && e_ar;
    pm_dest = md; pm_data = mdat;
    pa_dest = ad; pa_data = adat;
  endtask

  task automatic idleCycle(input logic [ADDR_W-1:0] qa, input logic [ADDR_W-1:0] qb);
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0, qa, qb);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (fire_m) enqueue(pm_dest, pm_data);
    if (fire_a) enqueue(pa_dest, pa_data);
    fire_m = 1'b0;
    fire_a = 1'b0;
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      idleCycle(ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)));
      if (exp_count == 0) break;
      tick();
    end
    checkOutput("drain_busy", busy, 1'b0);
  endtask

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int n_p;
    int p_cyc [2];
    int p_dst [2];
    bit done;

    vecs[0] = '{1'b0, 5'd5,  16'h1234, 1'b1, 5'd5,  16'h1234};
    vecs[1] = '{1'b1, 5'd31, 16'hBEEF, 1'b1, 5'd31, 16'hBEEF};
    vecs[2] = '{1'b0, 5'd0,  16'hFFFF, 1'b0, 5'd0,  16'h0000};
    vecs[3] = '{1'b1, 5'd0,  16'h0001, 1'b0, 5'd0,  16'h0000};
    vecs[4] = '{1'b0, 5'd1,  16'h0000, 1'b1, 5'd1,  16'h0000};
    vecs[5] = '{1'b1, 5'd16, 16'h8001, 1'b1, 5'd16, 16'h8001};

    rst = 1'b1;
    mem_valid = 0; mem_dest = 0; mem_data = 0;
    alu_valid = 0; alu_dest = 0; alu_data = 0;
    fwd_readA = 0; fwd_readB = 0;
    modelReset();
    #3;
    checkOutput("reset_reg_wrt", reg_wrt, 1'b0);
    checkOutput("reset_dest", dest, 5'd0);
    checkOutput("reset_data", data, 16'h0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_mem_ready", mem_ready, 1'b1);
    checkOutput("reset_alu_ready", alu_ready, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;

    // Table of single writes, each followed through E0..E3
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].use_mem) applyStimulus(1'b1, vecs[v].dst, vecs[v].dat, 1'b0, 5'd0, 16'h0, 5'd0, 5'd0);
      else                 applyStimulus(1'b0, 5'd0, 16'h0, 1'b1, vecs[v].dst, vecs[v].dat, 5'd0, 5'd0);
      checkOutput($sformatf("vec%0d_ready", v), vecs[v].use_mem ? mem_ready : alu_ready, 1'b1);
      tick();
      idleCycle(vecs[v].dst, 5'd0);
      checkOutput($sformatf("vec%0d_busy_e0", v), busy, vecs[v].exp_pulse);
      checkOutput($sformatf("vec%0d_fwd_e0", v), fwd_hit_a, vecs[v].exp_pulse);
      tick();
      idleCycle(5'd0, 5'd0);
      checkOutput($sformatf("vec%0d_wrt_e1", v), reg_wrt, 1'b0);
      if (vecs[v].exp_pulse) checkOutput($sformatf("vec%0d_dest_e1", v), dest, vecs[v].exp_dest);
      tick();
      idleCycle(5'd0, 5'd0);
      checkOutput($sformatf("vec%0d_wrt_e2", v), reg_wrt, vecs[v].exp_pulse);
      if (vecs[v].exp_pulse) begin
        checkOutput($sformatf("vec%0d_dest_e2", v), dest, vecs[v].exp_dest);
        checkOutput($sformatf("vec%0d_data_e2", v), data, vecs[v].exp_data);
      end
      tick();
      idleCycle(5'd0, 5'd0);
      checkOutput($sformatf("vec%0d_wrt_e3", v), reg_wrt, 1'b0);
      checkOutput($sformatf("vec%0d_busy_e3", v), busy, 1'b0);
      tick();
    end

    // Dual accept: mem (older) must be written before alu, two cycles apart
    applyStimulus(1'b1, 5'd3, 16'hAAAA, 1'b1, 5'd4, 16'h5555, 5'd0, 5'd0);
    checkOutput("dual_mem_ready", mem_ready, 1'b1);
    checkOutput("dual_alu_ready", alu_ready, 1'b1);
    tick();
    n_p = 0;
    p_cyc[0] = 0; p_cyc[1] = 0; p_dst[0] = 0; p_dst[1] = 0;
    for (int i = 1; i <= 8; i++) begin
      idleCycle(5'd0, 5'd0);
      if (reg_wrt === 1'b1) begin
        if (n_p < 2) begin
          p_cyc[n_p] = i;
          p_dst[n_p] = int'(dest);
        end
        n_p++;
      end
      tick();
    end
    checkOutput("dual_pulse_count", n_p, 2);
    checkOutput("dual_first_dest", p_dst[0], 3);
    checkOutput("dual_second_dest", p_dst[1], 4);
    checkOutput("dual_spacing", p_cyc[1] - p_cyc[0], 2);
    drain();
    tick();

    // Backpressure: fill to DEPTH, then see alu refused at count=3
    applyStimulus(1'b1, 5'd10, 16'h0A0A, 1'b1, 5'd11, 16'h0B0B, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b1, 5'd12, 16'h0C0C, 1'b1, 5'd13, 16'h0D0D, 5'd0, 5'd0);
    checkOutput("bp_alu_ready_cnt2", alu_ready, 1'b1);
    tick();
    applyStimulus(1'b1, 5'd14, 16'h0E0E, 1'b1, 5'd15, 16'h0F0F, 5'd0, 5'd0);
    checkOutput("bp_full_mem_ready", mem_ready, 1'b0);
    checkOutput("bp_full_alu_ready", alu_ready, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd14, 16'h0E0E, 1'b1, 5'd15, 16'h0F0F, 5'd0, 5'd0);
    checkOutput("bp_still_full", mem_ready, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd14, 16'h0E0E, 1'b1, 5'd15, 16'h0F0F, 5'd0, 5'd0);
    checkOutput("bp_cnt3_mem_ready", mem_ready, 1'b1);
    checkOutput("bp_cnt3_alu_ready", alu_ready, 1'b0);
    tick();
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      applyStimulus(1'b0, 5'd0, 16'h0, 1'b1, 5'd15, 16'h0F0F, 5'd15, 5'd14);
      if (fire_a) done = 1'b1;
      tick();
    end
    checkOutput("bp_alu_accepted", done, 1'b1);
    drain();
    tick();

    // Forwarding: youngest of two r7 writes wins, query 0 never hits
    applyStimulus(1'b1, 5'd7, 16'h0011, 1'b1, 5'd7, 16'h0022, 5'd0, 5'd0);
    tick();
    idleCycle(5'd7, 5'd0);
    checkOutput("fwd_r7_hit", fwd_hit_a, 1'b1);
    checkOutput("fwd_r7_data", fwd_data_a, 16'h0022);
    checkOutput("fwd_r0_hit", fwd_hit_b, 1'b0);
    checkOutput("fwd_r0_data", fwd_data_b, 16'h0);
    drain();
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom),
                    1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom),
                    ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)));
      tick();
    end
    drain();
    tick();

    // Reset in the middle of a WRITE cycle, between clock edges
    applyStimulus(1'b1, 5'd9, 16'h0909, 1'b1, 5'd10, 16'h0A0A, 5'd0, 5'd0);
    tick();
    idleCycle(5'd10, 5'd0);
    tick();
    idleCycle(5'd10, 5'd0);
    tick();
    idleCycle(5'd10, 5'd0);
    checkOutput("rstmid_pre_wrt", reg_wrt, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstmid_reg_wrt", reg_wrt, 1'b0);
    checkOutput("rstmid_dest", dest, 5'd0);
    checkOutput("rstmid_data", data, 16'h0);
    checkOutput("rstmid_busy", busy, 1'b0);
    checkOutput("rstmid_mem_ready", mem_ready, 1'b1);
    checkOutput("rstmid_alu_ready", alu_ready, 1'b1);
    checkOutput("rstmid_fwd_hit", fwd_hit_a, 1'b0);
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    modelReset();
    for (int i = 0; i < 4; i++) begin
      idleCycle(5'd9, 5'd10);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
